vga_sync_gen: RTL and testbench

- Generates 640x480 @ 60 Hz VGA timing from the board system clock: pixel-rate enable, raw horizontal/vertical counters, hsync, vsync, active-video and frame-start flags.
- Sits directly upstream of the character/blanking memory stage. That stage consumes Posx/Posy as raw counter values spanning the full line/frame, porches included.
- hsync/vsync go to the connector; video_on/frame_start go to the colour output stage.

---
 rtl/vga_sync_gen.sv | 98 +++++++++
 tb/tb_vga_sync_gen.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/vga_sync_gen.sv
// vga_sync_gen: 640x480 @ 60 Hz VGA timing generator (parameterisable).
//
// Ports:
//   Clk          system clock, all logic on the rising edge
//   reset        synchronous, active-high reset
//   Posx [9:0]   horizontal counter, 0..H_TOTAL-1 (porches included)
//   Posy [9:0]   vertical counter, 0..V_TOTAL-1 (porches included)
//   hsync        horizontal sync, active level SYNC_POL
//   vsync        vertical sync, active level SYNC_POL
//   video_on     high while Posx < H_DISPLAY and Posy < V_DISPLAY
//   pixel_tick   one-Clk pulse per pixel period
//   frame_start  one-Clk pulse in the cycle the counters show (0,0) after a wrap
//
// Every output is a register. The flags are decoded from the next-state
// counter values, so they always line up with Posx/Posy in the same cycle.
module vga_sync_gen #(
  parameter int DIV       = 4,
  parameter int H_DISPLAY = 640,
  parameter int H_FRONT   = 16,
  parameter int H_SYNC    = 96,
  parameter int H_BACK    = 48,
  parameter int V_DISPLAY = 480,
  parameter int V_FRONT   = 10,
  parameter int V_SYNC    = 2,
  parameter int V_BACK    = 33,
  parameter int SYNC_POL  = 0
) (
  input  logic       Clk,
  input  logic       reset,
  output logic [9:0] Posx,
  output logic [9:0] Posy,
  output logic       hsync,
  output logic       vsync,
  output logic       video_on,
  output logic       pixel_tick,
  output logic       frame_start
);

  localparam int H_TOTAL = H_DISPLAY + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_DISPLAY + V_FRONT + V_SYNC + V_BACK;

  localparam logic [3:0] DIV_LAST = 4'(DIV - 1);
  localparam logic [9:0] H_LAST   = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST   = 10'(V_TOTAL - 1);
  localparam logic [9:0] H_VIS    = 10'(H_DISPLAY);
  localparam logic [9:0] V_VIS    = 10'(V_DISPLAY);
  localparam logic [9:0] HS_FIRST = 10'(H_DISPLAY + H_FRONT);
  localparam logic [9:0] HS_LAST  = 10'(H_DISPLAY + H_FRONT + H_SYNC - 1);
  localparam logic [9:0] VS_FIRST = 10'(V_DISPLAY + V_FRONT);
  localparam logic [9:0] VS_LAST  = 10'(V_DISPLAY + V_FRONT + V_SYNC - 1);
  localparam logic       SYNC_ACT = 1'(SYNC_POL);

  logic [3:0] presc;
  logic [3:0] presc_nxt;
  logic [9:0] x_nxt;
  logic [9:0] y_nxt;
  logic       frame_end;

  always_comb begin
    presc_nxt = (presc == DIV_LAST) ? 4'd0 : presc + 4'd1;
    x_nxt     = Posx;
    y_nxt     = Posy;
    // pixel_tick is the registered copy, so counters step on the edge that
    // closes the tick cycle.
    frame_end = pixel_tick && (Posx == H_LAST) && (Posy == V_LAST);
    if (pixel_tick) begin
      if (Posx == H_LAST) begin
        x_nxt = 10'd0;
        y_nxt = (Posy == V_LAST) ? 10'd0 : Posy + 10'd1;
      end else begin
        x_nxt = Posx + 10'd1;
      end
    end
  end

  always_ff @(posedge Clk) begin
    if (reset) begin
      presc       <= 4'd0;
      pixel_tick  <= 1'b0;
      Posx        <= 10'd0;
      Posy        <= 10'd0;
      hsync       <= ~SYNC_ACT;
      vsync       <= ~SYNC_ACT;
      video_on    <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      presc       <= presc_nxt;
      pixel_tick  <= (presc_nxt == DIV_LAST);
      Posx        <= x_nxt;
      Posy        <= y_nxt;
      hsync       <= (x_nxt >= HS_FIRST && x_nxt <= HS_LAST) ? SYNC_ACT : ~SYNC_ACT;
      vsync       <= (y_nxt >= VS_FIRST && y_nxt <= VS_LAST) ? SYNC_ACT : ~SYNC_ACT;
      video_on    <= (x_nxt < H_VIS) && (y_nxt < V_VIS);
      frame_start <= frame_end;
    end
  end

endmodule

// File: tb/tb_vga_sync_gen.sv
// Bench for vga_sync_gen: three instances (default timing, a small DIV=1
// active-high variant with random resets, a small DIV=3 variant) checked
// every cycle against a closed-form timing model, plus literal spot checks.
module tb_vga_sync_gen;

  typedef struct packed {
    logic [9:0] x;
    logic [9:0] y;
    logic       hs;
    logic       vs;
    logic       von;
    logic       tick;
    logic       fs;
  } obs_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst_a, rst_b, rst_c;
  logic [9:0] x_a, y_a, x_b, y_b, x_c, y_c;
  logic hs_a, vs_a, von_a, tick_a, fs_a;
  logic hs_b, vs_b, von_b, tick_b, fs_b;
  logic hs_c, vs_c, von_c, tick_c, fs_c;

  vga_sync_gen dut_a (
    .Clk(clk), .reset(rst_a), .Posx(x_a), .Posy(y_a), .hsync(hs_a), .vsync(vs_a),
    .video_on(von_a), .pixel_tick(tick_a), .frame_start(fs_a));

  vga_sync_gen #(.DIV(1), .H_DISPLAY(8), .H_FRONT(2), .H_SYNC(3), .H_BACK(2),
                 .V_DISPLAY(6), .V_FRONT(1), .V_SYNC(2), .V_BACK(2), .SYNC_POL(1)) dut_b (
    .Clk(clk), .reset(rst_b), .Posx(x_b), .Posy(y_b), .hsync(hs_b), .vsync(vs_b),
    .video_on(von_b), .pixel_tick(tick_b), .frame_start(fs_b));

  vga_sync_gen #(.DIV(3), .H_DISPLAY(10), .H_FRONT(2), .H_SYNC(3), .H_BACK(3),
                 .V_DISPLAY(5), .V_FRONT(2), .V_SYNC(1), .V_BACK(2), .SYNC_POL(0)) dut_c (
    .Clk(clk), .reset(rst_c), .Posx(x_c), .Posy(y_c), .hsync(hs_c), .vsync(vs_c),
    .video_on(von_c), .pixel_tick(tick_c), .frame_start(fs_c));

  int n_chk = 0;
  int n_fail = 0;
  int k_a = 0, k_b = 0, k_c = 0;
  bit run_chk = 1'b0;
  int hs_low_a = 0;
  bit a_line_checked = 1'b0;
  int fs_cnt_c = 0, fs_k1_c = 0, fs_k2_c = 0;

  // Pixels completed after k edges since reset release. The tick register
  // is low through reset, so with DIV=1 the first edge never advances.
  function automatic int pix(int k, int div);
    return k / div - ((div == 1) ? 1 : 0);
  endfunction

  function automatic obs_t model(int k, int div, int hd, int hf, int hsw, int hb,
                                 int vd, int vf, int vsw, int vb, int pol);
    obs_t e;
    int ht, vt, n, np, xi, yi;
    logic act;
    act = (pol != 0);
    ht = hd + hf + hsw + hb;
    vt = vd + vf + vsw + vb;
    e.x = 10'd0; e.y = 10'd0; e.hs = ~act; e.vs = ~act;
    e.von = 1'b0; e.tick = 1'b0; e.fs = 1'b0;
    if (k > 0) begin
      n  = pix(k, div);
      xi = n % ht;
      yi = (n / ht) % vt;
      e.x = 10'(xi);
      e.y = 10'(yi);
      e.tick = ((k % div) == div - 1);
      e.hs = (xi >= hd + hf && xi < hd + hf + hsw) ? act : ~act;
      e.vs = (yi >= vd + vf && yi < vd + vf + vsw) ? act : ~act;
      e.von = (xi < hd) && (yi < vd);
      np = (k > 1) ? pix(k - 1, div) : 0;
      e.fs = (n > 0) && (n != np) && ((n % (ht * vt)) == 0);
    end
    return e;
  endfunction

  task automatic check_obs(string nm, int k, obs_t a, obs_t e);
    n_chk++;
    if (a !== e) begin
      n_fail++;
      $display("FAIL %s k=%0d got x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b expected x=%0d y=%0d hs=%b vs=%b von=%b tick=%b fs=%b",
               nm, k, a.x, a.y, a.hs, a.vs, a.von, a.tick, a.fs,
               e.x, e.y, e.hs, e.vs, e.von, e.tick, e.fs);
    end
  endtask

  task automatic check_val(string nm, int act, int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s got %0d expected %0d", nm, act, exp);
    end
  endtask

  always @(posedge clk) begin
    k_a <= rst_a ? 0 : k_a + 1;
    k_b <= rst_b ? 0 : k_b + 1;
    k_c <= rst_c ? 0 : k_c + 1;
  end

  // Cycle-by-cycle comparison against the model.
  always @(negedge clk) begin
    if (run_chk) begin
      check_obs("dut_a", k_a, {x_a, y_a, hs_a, vs_a, von_a, tick_a, fs_a},
                model(k_a, 4, 640, 16, 96, 48, 480, 10, 2, 33, 0));
      check_obs("dut_b", k_b, {x_b, y_b, hs_b, vs_b, von_b, tick_b, fs_b},
                model(k_b, 1, 8, 2, 3, 2, 6, 1, 2, 2, 1));
      check_obs("dut_c", k_c, {x_c, y_c, hs_c, vs_c, von_c, tick_c, fs_c},
                model(k_c, 3, 10, 2, 3, 3, 5, 2, 1, 2, 0));
    end
  end

  // Hand-computed literal expectations pinning the model.
  always @(negedge clk) begin
    if (run_chk) begin
      if (!a_line_checked && k_a >= 1 && k_a <= 3200 && hs_a == 1'b0) hs_low_a++;
      case (k_a)
        1:    begin check_val("a_k1_posx", x_a, 0); check_val("a_k1_video_on", von_a, 1);
                    check_val("a_k1_tick", tick_a, 0); end
        3:    begin check_val("a_k3_tick", tick_a, 1); check_val("a_k3_posx", x_a, 0); end
        4:    begin check_val("a_k4_posx", x_a, 1); check_val("a_k4_tick", tick_a, 0); end
        2559: begin check_val("a_x639_posx", x_a, 639); check_val("a_x639_video_on", von_a, 1); end
        2560: begin check_val("a_x640_posx", x_a, 640); check_val("a_x640_video_on", von_a, 0); end
        2623: check_val("a_x655_hsync", hs_a, 1);
        2624: begin check_val("a_x656_posx", x_a, 656); check_val("a_x656_hsync", hs_a, 0); end
        3199: begin check_val("a_x799_posx", x_a, 799); check_val("a_x799_posy", y_a, 0); end
        3200: begin
          check_val("a_wrap_posx", x_a, 0); check_val("a_wrap_posy", y_a, 1);
          if (!a_line_checked) check_val("a_hsync_low_clks", hs_low_a, 384);
          a_line_checked = 1'b1;
        end
        default: ;
      endcase
      case (k_b)
        1:   begin check_val("b_k1_posx", x_b, 0); check_val("b_k1_tick", tick_b, 1); end
        2:   check_val("b_k2_posx", x_b, 1);
        10:  check_val("b_x9_hsync", hs_b, 0);
        11:  check_val("b_x10_hsync", hs_b, 1);
        13:  check_val("b_x12_hsync", hs_b, 1);
        14:  check_val("b_x13_hsync", hs_b, 0);
        105: check_val("b_y6_vsync", vs_b, 0);
        106: begin check_val("b_y7_vsync", vs_b, 1); check_val("b_y7_posy", y_b, 7); end
        166: begin check_val("b_frame_start", fs_b, 1); check_val("b_fs_posy", y_b, 0); end
        default: ;
      endcase
      if (fs_c && k_c <= 1100) begin
        fs_cnt_c++;
        if (fs_cnt_c == 1) fs_k1_c = k_c;
        else if (fs_cnt_c == 2) fs_k2_c = k_c;
      end
    end
  end

  initial begin
    bit did_a, pending_a;
    did_a = 1'b0;
    pending_a = 1'b0;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    @(posedge clk);
    @(negedge clk);
    run_chk = 1'b1;
    repeat (10) @(negedge clk);
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    for (int i = 0; i < 20000; i++) begin
      @(negedge clk);
      rst_b = ($urandom_range(0, 499) == 0);
      if (pending_a) begin
        check_val("a_mid_reset_posx", x_a, 0);
        check_val("a_mid_reset_posy", y_a, 0);
        check_val("a_mid_reset_hsync", hs_a, 1);
        check_val("a_mid_reset_vsync", vs_a, 1);
        check_val("a_mid_reset_video_on", von_a, 0);
        check_val("a_mid_reset_tick", tick_a, 0);
        pending_a = 1'b0;
        rst_a = 1'b0;
      end else if (!did_a && k_a == 7600) begin
        check_val("a_pre_reset_posx", x_a, 300);
        check_val("a_pre_reset_posy", y_a, 2);
        rst_a = 1'b1;
        did_a = 1'b1;
        pending_a = 1'b1;
      end
    end
    check_val("a_mid_reset_reached", int'(did_a), 1);
    check_val("c_frame_start_count", fs_cnt_c, 2);
    check_val("c_frame_start_first_k", fs_k1_c, 540);
    check_val("c_frame_start_second_k", fs_k2_c, 1080);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
